ex_muldiv_unit: RTL and testbench

Multi-cycle RV32M multiply/divide sequencer attached to the EX stage beside the single-cycle alu.
- Accepts an M-extension operation from ID/EX.
- Stalls the pipeline while it iterates a shared shift-add / restoring-divide datapath.
- Presents a registered result with a one-cycle done strobe for the EX/MEM mux.
- Owns operand sign handling, iteration count and RISC-V corner-case results.

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/ex_muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide sequencer:
// funct3 encodings, sequencer states and operand-sign decode helpers.
package muldiv_pkg;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == MULH) || (f3 == MULHSU) || (f3 == DIV) || (f3 == REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == MULH) || (f3 == DIV) || (f3 == REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit beside the EX-stage alu. One shared
// adder/subtractor runs shift-add multiply or restoring divide on magnitudes.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; start loads operands and goes to CALC
// CALC  | one multiply/divide iteration per cycle, XLEN cycles
// FIX   | sign correction, half/quotient/remainder select, result write
// DONE  | done strobe; start here reloads straight into CALC
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_f3;
  logic              r_neg_a;
  logic              r_neg_b;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_sign_a;
  logic              w_sign_b;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_is_div;
  logic [XLEN+1:0]   w_x;
  logic [XLEN+1:0]   w_y;
  logic [XLEN+1:0]   w_sum;
  logic [XLEN:0]     w_prod_hi;
  logic [XLEN-1:0]   w_hi_nxt;
  logic [XLEN-1:0]   w_lo_nxt;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;

  assign w_accept = start && !flush && ((r_state == IDLE) || (r_state == DONE));
  assign stall    = (((r_state == IDLE) || (r_state == DONE)) && start)
                    || (r_state == CALC) || (r_state == FIX);
  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;

  assign w_sign_a = is_signed_a(funct3) && op_a[XLEN-1];
  assign w_sign_b = is_signed_b(funct3) && op_b[XLEN-1];
  assign w_mag_a  = w_sign_a ? -op_a : op_a;
  assign w_mag_b  = w_sign_b ? -op_b : op_b;

  // Divide feeds the shifted partial remainder (XLEN+1 bits) and subtracts.
  assign w_is_div = is_div(r_f3);
  assign w_x      = w_is_div ? {1'b0, r_hi, r_lo[XLEN-1]} : {2'b00, r_hi};
  assign w_y      = {2'b00, r_b};
  assign w_sum    = w_x + (w_is_div ? ~w_y : w_y) + {{(XLEN+1){1'b0}}, w_is_div};

  always_comb begin
    w_prod_hi = '0;
    w_hi_nxt  = r_hi;
    w_lo_nxt  = r_lo;
    if (w_is_div) begin
      if (!w_sum[XLEN+1]) begin
        w_hi_nxt = w_sum[XLEN-1:0];
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_nxt = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      w_prod_hi = r_lo[0] ? w_sum[XLEN:0] : {1'b0, r_hi};
      w_hi_nxt  = w_prod_hi[XLEN:1];
      w_lo_nxt  = {w_prod_hi[0], r_lo[XLEN-1:1]};
    end
  end

  // A zero divisor leaves the dividend in r_hi, so REM/REMU already return op_a;
  // signed overflow also falls out of the magnitude path as 0x80..0 / 0.
  always_comb begin
    w_prod_s  = (r_neg_a ^ r_neg_b) ? -{r_hi, r_lo} : {r_hi, r_lo};
    w_quo     = (r_b == '0) ? '1 : ((r_neg_a ^ r_neg_b) ? -r_lo : r_lo);
    w_rem     = r_neg_a ? -r_hi : r_hi;
    w_fix_res = '0;
    case (r_f3)
      MUL:                 w_fix_res = w_prod_s[XLEN-1:0];
      MULH, MULHSU, MULHU: w_fix_res = w_prod_s[2*XLEN-1:XLEN];
      DIV, DIVU:           w_fix_res = w_quo;
      default:             w_fix_res = w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush && (r_state != IDLE)) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else if (w_accept) begin
        r_state <= CALC;
        r_busy  <= 1'b1;
        r_cnt   <= '0;
        r_f3    <= funct3;
        r_neg_a <= w_sign_a;
        r_neg_b <= w_sign_b;
        r_b     <= w_mag_b;
        r_hi    <= '0;
        r_lo    <= w_mag_a;
      end else begin
        case (r_state)
          CALC: begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_ITER) r_state <= FIX;
          end
          FIX: begin
            r_result <= w_fix_res;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed RV32M cases plus random operations checked
// against a 64-bit arithmetic reference, with latency, flush and reset checks.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_res = 32'd0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = 64'd0;
    case (f3)
      MUL:    begin p = sa * sb; return p[31:0];  end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  begin p = ua * ub; return p[63:32]; end
      DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub;
        return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub;
        return p[31:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Start an operation in the current cycle (cycle 0).
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; funct3 = f3; op_a = a; op_b = b;
    @(negedge clk);
    chk("stall_c0", {31'd0, stall}, 32'd1);
  endtask

  // Follow cycles 1..34; with chain set, a new op is requested during DONE.
  task automatic watch(input logic [31:0] exp, input bit chain, input logic [2:0] f3n,
                       input logic [31:0] an, input logic [31:0] bn);
    int          n_stall;
    int          n_done;
    int          done_cyc;
    logic [31:0] res;
    logic        busy1;
    logic        busy33;
    logic        busy34;
    n_stall = 0; n_done = 0; done_cyc = -1; res = 32'd0;
    busy1 = 1'b0; busy33 = 1'b0; busy34 = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      @(posedge clk); #1;
      if (chain && c == 34) begin
        start = 1'b1; funct3 = f3n; op_a = an; op_b = bn;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (stall) n_stall++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = c;
          res = result;
        end
      end
      if (c == 1)  busy1  = busy;
      if (c == 33) busy33 = busy;
      if (c == 34) busy34 = busy;
    end
    chk("stall_cycles", 32'(n_stall), chain ? 32'd34 : 32'd33);
    chk("done_cycle", 32'(done_cyc), 32'd34);
    chk("done_count", 32'(n_done), 32'd1);
    chk("result", res, exp);
    chk("busy_calc", {31'd0, busy1}, 32'd1);
    chk("busy_fix", {31'd0, busy33}, 32'd1);
    chk("busy_done", {31'd0, busy34}, 32'd0);
    last_res = exp;
    if (!chain) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("done_drop", {31'd0, done}, 32'd0);
      chk("stall_idle", {31'd0, stall}, 32'd0);
    end
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    issue(f3, a, b);
    watch(exp, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op(MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    run_op(MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF);
    run_op(DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    run_op(REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    run_op(DIVU,   32'd100,        32'd7,         32'd14);
    run_op(REMU,   32'd100,        32'd7,         32'd2);
    run_op(DIV,    32'd5,          32'd0,         32'hFFFF_FFFF);
    run_op(REM,    32'd5,          32'd0,         32'd5);
    run_op(DIVU,   32'h8000_0000,  32'd0,         32'hFFFF_FFFF);
    run_op(DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    run_op(REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0);

    // Flush during CALC: back to IDLE next cycle, no done, result held.
    issue(DIV, 32'd1000, 32'd3);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 10) flush = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    begin
      int n_done;
      n_done = (done === 1'b1) ? 1 : 0;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (done) n_done++;
      end
      chk("flush_no_done", 32'(n_done), 32'd0);
    end
    chk("flush_result", result, last_res);

    // Asynchronous reset mid-operation.
    issue(MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_res = 32'd0;
    run_op(MULHU, 32'h1234_5678, 32'h9ABC_DEF0, ref_model(MULHU, 32'h1234_5678, 32'h9ABC_DEF0));

    // Back-to-back: MUL 3*4 requested during the DIVU's DONE cycle.
    issue(DIVU, 32'd100, 32'd7);
    watch(32'd14, 1'b1, MUL, 32'd3, 32'd4);
    watch(32'd12, 1'b0, 3'd0, 32'd0, 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      f3 = 3'($urandom_range(0, 7));
      a  = rnd_op();
      b  = rnd_op();
      run_op(f3, a, b, ref_model(f3, a, b));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
